// File: rtl/gearbox_rx_param.sv
// gearbox_rx_param
//   RX gearbox between the PMA deserializer and block sync. Accepts IN_W-bit
//   PMA words every cycle and emits 66-bit blocks (HEAD_W-bit sync header plus
//   DATA_W-bit payload). A bit-count accumulator handles any PMA width from
//   8 to 66. Block sync can request a 1-bit slip to move the block boundary.
//   Loss of lock flushes the buffer.
//
// Ports
//   clk      : clock
//   nreset   : asynchronous active-low reset
//   lock_v_i : PMA lock; when low, data_i is ignored and the buffer is flushed
//   data_i   : PMA word, bit 0 is the oldest bit on the wire
//   slip_v_i : drop one bit to realign the block boundary
//   valid_o  : head_o/data_o carry a new block this cycle
//   head_o   : sync header (oldest HEAD_W bits of the block)
//   data_o   : block payload
//   lvl_o    : current buffer fill in bits (debug view of the fill counter)
//
// Handshake: valid-only stream. There is no ready. valid_o is high for exactly
// one cycle per emitted block, and the consumer must take the block in that
// cycle. head_o/data_o hold their last block while valid_o is low.
module gearbox_rx_param #(
  parameter int IN_W   = 32,
  parameter int HEAD_W = 2,
  parameter int DATA_W = 64,
  parameter int CNT_W  = $clog2(HEAD_W + DATA_W + 2 * IN_W)
) (
  input  logic              clk,
  input  logic              nreset,
  input  logic              lock_v_i,
  input  logic [IN_W-1:0]   data_i,
  input  logic              slip_v_i,
  output logic              valid_o,
  output logic [HEAD_W-1:0] head_o,
  output logic [DATA_W-1:0] data_o,
  output logic [CNT_W-1:0]  lvl_o
);

  localparam int BLOCK_W = HEAD_W + DATA_W;
  // The buffer never needs to hold more than one partial block plus one word.
  localparam int BUF_W   = BLOCK_W + IN_W - 1;
  localparam int COMB_W  = BUF_W + IN_W;

  localparam logic [CNT_W-1:0] BLOCK_CNT = CNT_W'(BLOCK_W);
  localparam logic [CNT_W-1:0] IN_CNT    = CNT_W'(IN_W);

  generate
    if (IN_W < 8 || IN_W > 66) begin : g_bad_in_w
      $error("gearbox_rx_param: IN_W must be within 8..66");
    end
  endgenerate

  logic [BUF_W-1:0]  buf_q;
  logic [BUF_W-1:0]  buf_d;
  logic [CNT_W-1:0]  cnt_q;
  logic [CNT_W-1:0]  cnt_d;
  logic [CNT_W-1:0]  pop;
  logic              pop_blk;
  logic [COMB_W-1:0] low_mask;
  logic [COMB_W-1:0] comb;

  always_comb begin
    pop_blk  = (cnt_q >= BLOCK_CNT);
    // A slip removes the bit directly after the emitted block. When no block
    // is emitted, it removes the oldest buffered bit, or data_i[0] when the
    // buffer is empty.
    pop      = (pop_blk ? BLOCK_CNT : '0) + (slip_v_i ? CNT_W'(1) : '0);
    // Bits at or above cnt_q in buf_q are stale, so mask them before the new
    // word is placed on top of the valid bits.
    low_mask = ~({COMB_W{1'b1}} << cnt_q);
    comb     = ({{IN_W{1'b0}}, buf_q} & low_mask) | (COMB_W'(data_i) << cnt_q);
    buf_d    = BUF_W'(comb >> pop);
    cnt_d    = cnt_q + IN_CNT - pop;
    if (!lock_v_i) begin
      buf_d = '0;
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      buf_q   <= '0;
      cnt_q   <= '0;
      valid_o <= 1'b0;
      head_o  <= '0;
      data_o  <= '0;
    end else begin
      buf_q   <= buf_d;
      cnt_q   <= cnt_d;
      valid_o <= lock_v_i && pop_blk;
      if (lock_v_i && pop_blk) begin
        {data_o, head_o} <= buf_q[BLOCK_W-1:0];
      end
    end
  end

  assign lvl_o = cnt_q;

endmodule

// File: tb/tb_gearbox_rx_param.sv
module tb_gearbox_rx_param;

  localparam int IN_W    = 32;
  localparam int HEAD_W  = 2;
  localparam int DATA_W  = 64;
  localparam int BLOCK_W = 66;
  localparam int CNT_W   = $clog2(BLOCK_W + 2 * IN_W);
  localparam int IN_W64  = 64;
  localparam int CNT_W64 = $clog2(BLOCK_W + 2 * IN_W64);

  // ---------------------------------------------------------------- clock/reset
  logic clk;
  logic nreset;
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------------------------------------------------------- DUT (IN_W=32)
  logic              lock_v;
  logic              slip_v;
  logic [IN_W-1:0]   data_in;
  logic              valid_o;
  logic [HEAD_W-1:0] head_o;
  logic [DATA_W-1:0] data_o;
  logic [CNT_W-1:0]  lvl_o;

  gearbox_rx_param #(.IN_W(IN_W)) u_dut (
    .clk      (clk),
    .nreset   (nreset),
    .lock_v_i (lock_v),
    .data_i   (data_in),
    .slip_v_i (slip_v),
    .valid_o  (valid_o),
    .head_o   (head_o),
    .data_o   (data_o),
    .lvl_o    (lvl_o)
  );

  // ---------------------------------------------------------------- DUT (IN_W=64)
  logic               lock64;
  logic               slip64;
  logic [IN_W64-1:0]  data64;
  logic               valid64;
  logic [HEAD_W-1:0]  head64;
  logic [DATA_W-1:0]  dout64;
  logic [CNT_W64-1:0] lvl64;

  gearbox_rx_param #(.IN_W(IN_W64)) u_dut64 (
    .clk      (clk),
    .nreset   (nreset),
    .lock_v_i (lock64),
    .data_i   (data64),
    .slip_v_i (slip64),
    .valid_o  (valid64),
    .head_o   (head64),
    .data_o   (dout64),
    .lvl_o    (lvl64)
  );

  // ---------------------------------------------------------------- scoreboard
  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference model: the buffer is a plain queue of wire bits, oldest first.
  bit                 mq[$];
  logic [BLOCK_W-1:0] m_blk;
  logic               m_valid;

  task automatic model_reset();
    mq.delete();
    m_blk   = '0;
    m_valid = 1'b0;
  endtask

  task automatic model_step(input logic lock, input logic slip, input logic [IN_W-1:0] d);
    bit blk;
    if (!lock) begin
      mq.delete();
      m_valid = 1'b0;
    end else begin
      blk = (mq.size() >= BLOCK_W);
      for (int j = 0; j < IN_W; j++) mq.push_back(d[j]);
      if (blk) begin
        for (int j = 0; j < BLOCK_W; j++) m_blk[j] = mq.pop_front();
      end
      if (slip) void'(mq.pop_front());
      m_valid = blk;
    end
  endtask

  // ---------------------------------------------------------------- driver tasks
  task automatic step(input logic lock, input logic slip, input logic [IN_W-1:0] d,
                      input string tag);
    lock_v  = lock;
    slip_v  = slip;
    data_in = d;
    @(posedge clk);
    #1;
    model_step(lock, slip, d);
    check({tag, ".valid"}, valid_o, m_valid);
    check({tag, ".lvl"},   lvl_o,   mq.size());
    check({tag, ".head"},  head_o,  m_blk[1:0]);
    check({tag, ".data"},  data_o,  m_blk[BLOCK_W-1:2]);
  endtask

  task automatic do_reset(input string tag);
    nreset  = 1'b0;
    lock_v  = 1'b0;
    slip_v  = 1'b0;
    data_in = '0;
    @(posedge clk);
    #1;
    check({tag, ".rst_valid"}, valid_o, 0);
    check({tag, ".rst_head"},  head_o,  0);
    check({tag, ".rst_data"},  data_o,  0);
    check({tag, ".rst_lvl"},   lvl_o,   0);
    nreset = 1'b1;
    model_reset();
  endtask

  // ---------------------------------------------------------------- vector table
  typedef struct {
    logic               lock;
    logic               slip;
    logic [IN_W-1:0]    data;
    logic               exp_valid;
    int                 exp_lvl;
    logic               chk_blk;
    logic [BLOCK_W-1:0] exp_blk;
  } tv_t;

  tv_t             tv[12];
  logic [IN_W-1:0] w[6];
  logic [IN_W-1:0] r[5];

  // ---------------------------------------------------------------- main test
  initial begin
    logic [IN_W-1:0]    s[4];
    logic [3*IN_W-1:0]  cat;
    logic [BLOCK_W-1:0] src[8];
    bit                 bq[$];
    logic [IN_W-1:0]    wd;
    int                 nb;
    logic [30:0]        lfsr;
    bit                 inq[$];
    bit                 outq[$];
    int                 nvalid, nbub, badpos, nmis;
    logic [IN_W64-1:0]  wd64;
    bit                 fb;

    nreset  = 1'b1;
    lock_v  = 1'b0;
    slip_v  = 1'b0;
    data_in = '0;
    lock64  = 1'b0;
    slip64  = 1'b0;
    data64  = '0;
    model_reset();
    #3;

    // ---- directed table: fill sequence, lock drop, relock alignment
    do_reset("tbl");
    for (int k = 0; k < 6; k++) w[k] = 32'h0403_0201 + k * 32'h0404_0404;
    for (int k = 0; k < 5; k++) r[k] = $urandom;
    tv[0]  = '{1'b1, 1'b0, w[0], 1'b0, 32, 1'b0, '0};
    tv[1]  = '{1'b1, 1'b0, w[1], 1'b0, 64, 1'b0, '0};
    tv[2]  = '{1'b1, 1'b0, w[2], 1'b0, 96, 1'b0, '0};
    tv[3]  = '{1'b1, 1'b0, w[3], 1'b1, 62, 1'b1, {w[2][1:0], w[1], w[0]}};
    tv[4]  = '{1'b1, 1'b0, w[4], 1'b0, 94, 1'b0, '0};
    tv[5]  = '{1'b1, 1'b0, w[5], 1'b1, 60, 1'b1, {w[4][3:0], w[3], w[2][31:2]}};
    tv[6]  = '{1'b0, 1'b0, w[5], 1'b0, 0,  1'b1, {w[4][3:0], w[3], w[2][31:2]}};
    tv[7]  = '{1'b1, 1'b0, r[0], 1'b0, 32, 1'b0, '0};
    tv[8]  = '{1'b1, 1'b0, r[1], 1'b0, 64, 1'b0, '0};
    tv[9]  = '{1'b1, 1'b0, r[2], 1'b0, 96, 1'b0, '0};
    tv[10] = '{1'b1, 1'b0, r[3], 1'b1, 62, 1'b1, {r[2][1:0], r[1], r[0]}};
    tv[11] = '{1'b1, 1'b0, r[4], 1'b0, 94, 1'b1, {r[2][1:0], r[1], r[0]}};
    for (int k = 0; k < 12; k++) begin
      step(tv[k].lock, tv[k].slip, tv[k].data, $sformatf("tbl%0d", k));
      check($sformatf("tbl%0d.exp_valid", k), valid_o, tv[k].exp_valid);
      check($sformatf("tbl%0d.exp_lvl", k),   lvl_o,   tv[k].exp_lvl);
      if (tv[k].chk_blk) check($sformatf("tbl%0d.exp_blk", k), {data_o, head_o}, tv[k].exp_blk);
    end

    // ---- slip with an empty buffer drops data_i[0]
    do_reset("slip0");
    for (int k = 0; k < 4; k++) s[k] = $urandom;
    step(1'b1, 1'b1, s[0], "slip0_c0");
    check("slip0.lvl_in_w_minus_1", lvl_o, IN_W - 1);
    step(1'b1, 1'b0, s[1], "slip0_c1");
    step(1'b1, 1'b0, s[2], "slip0_c2");
    step(1'b1, 1'b0, s[3], "slip0_c3");
    cat = {s[2], s[1], s[0]};
    check("slip0.first_valid", valid_o, 1);
    check("slip0.first_block", {data_o, head_o}, cat[BLOCK_W:1]);

    // ---- async reset between edges while a block is presented
    #2;
    nreset = 1'b0;
    #1;
    check("areset.valid", valid_o, 0);
    check("areset.head",  head_o,  0);
    check("areset.data",  data_o,  0);
    check("areset.lvl",   lvl_o,   0);
    @(posedge clk);
    #1;
    nreset = 1'b1;
    model_reset();
    for (int k = 0; k < 4; k++) begin
      step(1'b1, 1'b0, $urandom, "areset_refill");
      check($sformatf("areset.refill_valid%0d", k), valid_o, k == 3);
    end

    // ---- stream of legal blocks offset by 3 bits, removed by 3 slips
    do_reset("slip3");
    for (int j = 0; j < 3; j++) bq.push_back(1'($urandom_range(0, 1)));
    for (int b = 0; b < 8; b++) begin
      src[b] = {$urandom, $urandom, 2'($urandom_range(1, 2))};
      for (int j = 0; j < BLOCK_W; j++) bq.push_back(src[b][j]);
    end
    while (bq.size() < 20 * IN_W) bq.push_back(1'b0);
    nb = 0;
    for (int k = 0; k < 20; k++) begin
      for (int j = 0; j < IN_W; j++) wd[j] = bq.pop_front();
      step(1'b1, (k < 3), wd, "slip3");
      if (valid_o) begin
        if (nb < 8) begin
          check($sformatf("slip3.head_legal%0d", nb), (head_o == 2'b01) || (head_o == 2'b10), 1);
          check($sformatf("slip3.block%0d", nb), {data_o, head_o}, src[nb]);
        end
        nb++;
      end
    end
    check("slip3.nblk_ge8", nb >= 8, 1);
    check("slip3.lvl_minus3", lvl_o, 20 * IN_W - 3 - BLOCK_W * nb);

    // ---- randomized run against the model (lock drops and slips)
    do_reset("rand");
    for (int k = 0; k < 400; k++) begin
      step($urandom_range(0, 49) != 0, $urandom_range(0, 9) == 0, $urandom, "rand");
      check("rand.lvl_bound", lvl_o <= BLOCK_W - 1 + IN_W, 1);
    end

    // ---- IN_W=64: PRBS31, 32 of every 33 cycles valid, bitstream preserved
    lfsr   = 31'h1234_5678;
    nvalid = 0;
    nbub   = 0;
    badpos = 0;
    lock64 = 1'b1;
    for (int k = 1; k <= 332; k++) begin
      for (int j = 0; j < IN_W64; j++) begin
        fb      = lfsr[30] ^ lfsr[27];
        lfsr    = {lfsr[29:0], fb};
        wd64[j] = fb;
        inq.push_back(fb);
      end
      data64 = wd64;
      @(posedge clk);
      #1;
      if (valid64) begin
        nvalid++;
        for (int j = 0; j < HEAD_W; j++) outq.push_back(head64[j]);
        for (int j = 0; j < DATA_W; j++) outq.push_back(dout64[j]);
      end else if (k >= 3) begin
        nbub++;
        if ((k - 2) % 33 != 0) badpos++;
      end
    end
    lock64 = 1'b0;
    check("prbs.valid_count", nvalid, 320);
    check("prbs.bubble_count", nbub, 10);
    check("prbs.bubble_position", badpos, 0);
    check("prbs.out_bits", outq.size(), 320 * BLOCK_W);
    check("prbs.final_lvl", lvl64, 332 * IN_W64 - 320 * BLOCK_W);
    nmis = 0;
    for (int i = 0; i < outq.size() && i < inq.size(); i++) begin
      if (outq[i] != inq[i]) nmis++;
    end
    check("prbs.bit_mismatches", nmis, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
